sn74xx_mod_counter: RTL and testbench
=====================================

# sn74xx_mod_counter

Parametrised synchronous modulo-N counter, the successor to the fixed 4-bit ripple binary counter in the sn74 library. It adds programmable width and modulus, up/down counting, synchronous parallel load, 161-style dual count enables, and a selectable active clock edge. It also provides a combinational ripple-carry output for cascading and a registered wrap pulse. It sits in the sn74 library as the general counter primitive for dividers, timers and cascaded counter chains.

## Interface
- WIDTH, 4, counter width in bits (1..32)
- MODULUS, 16, count modulus N; legal range 2..2^WIDTH; counts span 0..N-1
- NEG_EDGE, 1, 1 = active edge is falling edge of clk (sn74 family default), 0 = rising edge
- clk  in  1  clock; the active edge is selected by NEG_EDGE
- clr  in  1  asynchronous clear, active-high; forces out=0, wrap=0 immediately
- load  in  1  synchronous parallel load, active-high
- d  in  WIDTH  parallel load value
- enp  in  1  count enable P (parallel)
- ent  in  1  count enable T (trickle); also gates rco
- up  in  1  direction: 1 = up, 0 = down
- out  out  WIDTH  count value
- rco  out  1  ripple carry out, combinational
- wrap  out  1  registered pulse: high for one clock period after a terminal-count wrap

## Operation
- Priority per active edge: clr > load > count > hold.
- clr=1 (async): out=0, wrap=0 immediately; all active edges are ignored while clr is high.
- load=1: out <= (d >= MODULUS) ? MODULUS-1 : d. enp, ent and up are ignored. wrap <= 0.
- Count (load=0, enp=1, ent=1):
  - up=1: out==MODULUS-1 -> 0, else out+1.
  - up=0: out==0 -> MODULUS-1, else out-1.
  - wrap <= 1 only on the edge where the wrap transition occurs; otherwise wrap <= 0.
- Hold (enp=0 or ent=0): out is unchanged; wrap <= 0.
- rco = ent & (up ? out==MODULUS-1 : out==0). It is purely combinational so cascaded stages advance on the same edge. Connect rco to the next stage's ent and tie clk in common.
- Out-of-range out is reachable only via illegal parameters; that case is not supported. Elaboration must fail if MODULUS < 2 or MODULUS > 2^WIDTH.
- When MODULUS = 2^WIDTH, the counter wraps naturally. The implementation must not overflow intermediate arithmetic; compare against MODULUS-1 in WIDTH+1 bits.

## Timing
- Reset values: out=0, wrap=0. rco = ent & up==0 while cleared (out==0 is down-terminal).
- out and wrap update on the active edge with zero-delay model semantics, using non-blocking assignment.
- Latency: a load or count takes effect on the first active edge with the enabling inputs stable before it.
- Changing up, ent or out changes rco in the same timestep. A change to up takes effect on out at the next active edge.
- clr deassertion must not coincide with an active edge. The first active edge after release is evaluated normally.
- Simultaneous load and enables: load wins. A load of MODULUS-1 with up=1 gives wrap=0; the next counting edge wraps.
- clr asserted mid-period: out drops to 0 at once, and a pending wrap pulse is cancelled.

## Test plan
- WIDTH=4, MODULUS=10, NEG_EDGE=1. Pulse clr; set enp=ent=up=1; apply 12 falling edges. Required: out=1..9,0,1,2; rco=1 only while out=9; wrap=1 only in the period following the 9->0 edge.
- Same config, up=0 from out=0. Required: rco=1 before the edge; one falling edge gives out=9, wrap=1; the next edge gives out=8, wrap=0.
- load=1, enp=0, d=7, one edge: out=7. Then d=13, one edge: out=9 (clamped). Then load=1 with enp=ent=1, d=3: out=3 (load wins).
- enp=1, ent=0 at out=9, up=1: out holds across 4 edges; rco=0. Raising ent gives rco=1 immediately.
- Counting at out=5: assert clr between edges. out=0 and wrap=0 in the same timestep; 3 edges with clr=1 leave out=0; after release, one edge gives out=1.
- Two instances, WIDTH=4, MODULUS=16, NEG_EDGE=0, cascaded (low.rco -> high.ent, shared clk/clr). Apply 256 rising edges from 0. Required: the combined {high,low} value steps 0..255; high.rco & low.rco at 255; both outputs return to 0 on edge 256, with wrap=1 on both.

Source files
------------

// File: rtl/sn74xx_mod_counter.sv
// Parametrised synchronous modulo-N up/down counter with 161-style dual enables,
// synchronous load with clamping, combinational ripple carry and registered wrap pulse.
module sn74xx_mod_counter #(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter bit              NEG_EDGE = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             enp,
    input  logic             ent,
    input  logic             up,
    output logic [WIDTH-1:0] out,
    output logic             rco,
    output logic             wrap
);

    localparam longint unsigned LP_SPAN = 64'd1 << WIDTH;

    generate
        if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 || MODULUS > LP_SPAN) begin : g_bad_params
            $error("sn74xx_mod_counter: illegal WIDTH/MODULUS combination");
        end
    endgenerate

    // Terminal comparisons use WIDTH+1 bits so MODULUS = 2^WIDTH cannot overflow.
    localparam logic [WIDTH:0]   LP_MOD  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   LP_TERM = (WIDTH+1)'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] LP_TOP  = LP_TERM[WIDTH-1:0];
    localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_out;
    logic             r_wrap;
    logic [WIDTH-1:0] w_out_nxt;
    logic             w_wrap_nxt;
    logic             w_is_top;
    logic             w_is_zero;
    logic             w_term;

    always_comb begin
        w_is_top  = ({1'b0, r_out} == LP_TERM);
        w_is_zero = (r_out == '0);
        w_term    = up ? w_is_top : w_is_zero;
    end

    always_comb begin
        w_out_nxt  = r_out;
        w_wrap_nxt = 1'b0;
        if (load) begin
            w_out_nxt = ({1'b0, d} >= LP_MOD) ? LP_TOP : d;
        end else if (enp && ent) begin
            if (up) begin
                w_out_nxt  = w_is_top ? '0 : r_out + LP_ONE;
                w_wrap_nxt = w_is_top;
            end else begin
                w_out_nxt  = w_is_zero ? LP_TOP : r_out - LP_ONE;
                w_wrap_nxt = w_is_zero;
            end
        end
    end

    generate
        if (NEG_EDGE) begin : g_neg_edge
            always_ff @(negedge clk or posedge clr) begin
                if (clr) begin
                    r_out  <= '0;
                    r_wrap <= 1'b0;
                end else begin
                    r_out  <= w_out_nxt;
                    r_wrap <= w_wrap_nxt;
                end
            end
        end else begin : g_pos_edge
            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    r_out  <= '0;
                    r_wrap <= 1'b0;
                end else begin
                    r_out  <= w_out_nxt;
                    r_wrap <= w_wrap_nxt;
                end
            end
        end
    endgenerate

    assign out  = r_out;
    assign wrap = r_wrap;
    assign rco  = ent & w_term;

endmodule

// File: tb/tb_sn74xx_mod_counter.sv
// Bench for sn74xx_mod_counter: a falling-edge MOD-10 instance against a behavioural
// model, plus a rising-edge cascade of two MOD-16 stages.
module tb_sn74xx_mod_counter;

    localparam int M = 10;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] d = '0;
    logic       enp = 1'b0;
    logic       ent = 1'b0;
    logic       up = 1'b0;
    logic [3:0] out;
    logic       rco;
    logic       wrap;

    logic       c_clr = 1'b0;
    logic [3:0] c_out_lo, c_out_hi;
    logic       c_rco_lo, c_rco_hi, c_wrap_lo, c_wrap_hi;

    int n_cmp = 0;
    int n_err = 0;

    int m_cnt  = 0;
    bit m_wrap = 1'b0;

    always #5 clk = ~clk;

    sn74xx_mod_counter #(.WIDTH(4), .MODULUS(10), .NEG_EDGE(1'b1)) u_dut (
        .clk(clk), .clr(clr), .load(load), .d(d), .enp(enp), .ent(ent), .up(up),
        .out(out), .rco(rco), .wrap(wrap)
    );

    sn74xx_mod_counter #(.WIDTH(4), .MODULUS(16), .NEG_EDGE(1'b0)) u_lo (
        .clk(clk), .clr(c_clr), .load(1'b0), .d(4'd0), .enp(1'b1), .ent(1'b1), .up(1'b1),
        .out(c_out_lo), .rco(c_rco_lo), .wrap(c_wrap_lo)
    );

    sn74xx_mod_counter #(.WIDTH(4), .MODULUS(16), .NEG_EDGE(1'b0)) u_hi (
        .clk(clk), .clr(c_clr), .load(1'b0), .d(4'd0), .enp(1'b1), .ent(c_rco_lo), .up(1'b1),
        .out(c_out_hi), .rco(c_rco_hi), .wrap(c_wrap_hi)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_rco();
        return ent && (up ? (m_cnt == M - 1) : (m_cnt == 0));
    endfunction

    // Behavioural reference: one active edge of a modulo-M counter.
    task automatic model_edge();
        if (clr) begin
            m_cnt  = 0;
            m_wrap = 1'b0;
        end else if (load) begin
            m_cnt  = (int'(d) >= M) ? M - 1 : int'(d);
            m_wrap = 1'b0;
        end else if (enp && ent) begin
            if (up) begin
                m_wrap = (m_cnt + 1 == M);
                m_cnt  = (m_cnt + 1) % M;
            end else begin
                m_wrap = (m_cnt == 0);
                m_cnt  = (m_cnt + M - 1) % M;
            end
        end else begin
            m_wrap = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out"}, 64'(out), 64'(m_cnt));
        chk({tag, ".wrap"}, 64'(wrap), 64'(m_wrap));
        chk({tag, ".rco"}, 64'(rco), 64'(model_rco()));
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic clear_mid(input string tag);
        #2;
        clr = 1'b1;
        m_cnt  = 0;
        m_wrap = 1'b0;
        #1;
        check_all(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        clr   = 1'b1;
        c_clr = 1'b1;
        #2;
        chk("reset.out", 64'(out), 64'd0);
        chk("reset.wrap", 64'(wrap), 64'd0);
        ent = 1'b1;
        up  = 1'b0;
        #1;
        chk("reset.rco_down", 64'(rco), 64'd1);
        up = 1'b1;
        #1;
        chk("reset.rco_up", 64'(rco), 64'd0);
        #1;
        clr = 1'b0;

        // Up count across the 9->0 boundary.
        enp = 1'b1;
        ent = 1'b1;
        up  = 1'b1;
        for (int i = 0; i < 12; i++) step("up");
        chk("up.final", 64'(out), 64'd2);

        // Down count from 0.
        clear_mid("clr_a");
        #2;
        clr = 1'b0;
        up  = 1'b0;
        #1;
        chk("down.rco_pre", 64'(rco), 64'd1);
        step("down1");
        chk("down1.val", 64'(out), 64'd9);
        step("down2");
        chk("down2.val", 64'(out), 64'd8);

        // Loads, clamping and load priority.
        load = 1'b1; enp = 1'b0; d = 4'd7;
        step("load7");
        d = 4'd13;
        step("load13");
        chk("clamp.val", 64'(out), 64'd9);
        enp = 1'b1; ent = 1'b1; d = 4'd3;
        step("load_wins");
        chk("load_wins.val", 64'(out), 64'd3);

        // Hold on ent=0 at the up terminal.
        d = 4'd9; up = 1'b1;
        step("load9");
        load = 1'b0; ent = 1'b0;
        #1;
        chk("hold.rco", 64'(rco), 64'd0);
        for (int i = 0; i < 4; i++) step("hold");
        ent = 1'b1;
        #1;
        chk("ent_rise.rco", 64'(rco), 64'd1);
        step("wrap_edge");
        chk("wrap_edge.wrap", 64'(wrap), 64'd1);
        clear_mid("wrap_cancel");
        #2;
        clr = 1'b0;

        // Async clear while counting at 5, held across three edges.
        load = 1'b1; d = 4'd4;
        step("load4");
        load = 1'b0;
        step("to5");
        chk("to5.val", 64'(out), 64'd5);
        clear_mid("clr_at5");
        for (int i = 0; i < 3; i++) step("clr_held");
        #1;
        clr = 1'b0;
        step("after_clr");
        chk("after_clr.val", 64'(out), 64'd1);

        // Randomised traffic with occasional mid-period clears.
        for (int i = 0; i < 400; i++) begin
            clr  = 1'b0;
            load = ($urandom_range(0, 7) == 0);
            d    = 4'($urandom_range(0, 15));
            enp  = ($urandom_range(0, 3) != 0);
            ent  = ($urandom_range(0, 3) != 0);
            up   = 1'($urandom_range(0, 1));
            #1;
            chk("rnd.rco_comb", 64'(rco), 64'(model_rco()));
            if ($urandom_range(0, 19) == 0) begin
                clear_mid("rnd.clr");
                if ($urandom_range(0, 1) == 0) begin
                    #2;
                    clr = 1'b0;
                end
            end
            step("rnd");
        end
        clr = 1'b0;

        // Cascade of two MOD-16 stages on rising edges.
        chk("casc.reset", {56'd0, c_out_hi, c_out_lo}, 64'd0);
        c_clr = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            @(posedge clk);
            #1;
            chk("casc.val", {56'd0, c_out_hi, c_out_lo}, 64'(k % 256));
            chk("casc.wrap_lo", 64'(c_wrap_lo), 64'((k % 16) == 0));
            chk("casc.wrap_hi", 64'(c_wrap_hi), 64'((k % 256) == 0));
            chk("casc.rco", 64'(c_rco_hi & c_rco_lo), 64'((k % 256) == 255));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
